// File: rtl/adc_sample_unpacker_if.sv
// Playback control, FWFT FIFO read port and unpacked sample stream of adc_sample_unpacker.
interface adc_sample_unpacker_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 play_start;
  logic [CNT_WIDTH-1:0] play_words;
  logic                 play_abort;
  logic [31:0]          word_in;
  logic                 word_empty;
  logic                 word_rd_en;
  logic [9:0]           sample_out;
  logic                 sample_or;
  logic                 sample_trig;
  logic                 sample_valid;
  logic                 play_busy;
  logic                 play_done;
  logic                 underrun;
  logic [CNT_WIDTH-1:0] words_done;

  modport master (
    output play_start, play_words, play_abort, word_in, word_empty,
    input  word_rd_en, sample_out, sample_or, sample_trig, sample_valid,
           play_busy, play_done, underrun, words_done
  );

  modport slave (
    input  play_start, play_words, play_abort, word_in, word_empty,
    output word_rd_en, sample_out, sample_or, sample_trig, sample_valid,
           play_busy, play_done, underrun, words_done
  );
endinterface

// File: rtl/adc_sample_unpacker.sv
// Unpacks 32-bit DDR capture words (3 x 10-bit samples + overrange/trigger flags)
// from an FWFT FIFO into one registered sample per adc_sampleclk.
module adc_sample_unpacker #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 adc_sampleclk,
  input  logic                 ddr_usrreset,
  adc_sample_unpacker_if.slave bus
);
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned SAMPLE_W = 10;
  localparam int unsigned PHASE_W  = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EMIT, ST_DONE} state_e;

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    hold_q, hold_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0] words_done_q, words_done_d;
  logic [SAMPLE_W-1:0]  sample_out_q, sample_out_d;
  logic                 sample_or_q, sample_or_d;
  logic                 sample_trig_q, sample_trig_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 play_busy_q, play_busy_d;
  logic                 play_done_q, play_done_d;
  logic                 underrun_q, underrun_d;
  logic                 word_rd_en_c;
  logic [SAMPLE_W-1:0]  field_c;

  // A word is taken from LOAD, or back-to-back on the last phase of a word when more remain.
  assign word_rd_en_c = !bus.word_empty &&
                        ((state_q == ST_LOAD) ||
                         ((state_q == ST_EMIT) && phase_q[2] && (remaining_q != '0)));

  always_comb begin
    field_c = hold_q[29:20];
    if (phase_q[0]) begin
      field_c = hold_q[9:0];
    end else if (phase_q[1]) begin
      field_c = hold_q[19:10];
    end
  end

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    phase_d        = phase_q;
    remaining_d    = remaining_q;
    words_done_d   = words_done_q;
    sample_out_d   = sample_out_q;
    sample_or_d    = sample_or_q;
    sample_trig_d  = sample_trig_q;
    sample_valid_d = 1'b0;
    play_done_d    = 1'b0;
    underrun_d     = underrun_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.play_start) begin
          if (bus.play_words != '0) begin
            remaining_d  = bus.play_words;
            underrun_d   = 1'b0;
            words_done_d = '0;
            state_d      = ST_LOAD;
          end else begin
            play_done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
      end
      ST_EMIT: begin
        sample_valid_d = 1'b1;
        sample_out_d   = field_c;
        sample_or_d    = hold_q[31];
        sample_trig_d  = hold_q[30];
        phase_d        = {phase_q[1:0], 1'b0};
        if (phase_q[2]) begin
          if (words_done_q != '1) begin
            words_done_d = words_done_q + CNT_WIDTH'(1);
          end
          if (remaining_q == '0) begin
            state_d = ST_DONE;
          end else if (bus.word_empty) begin
            underrun_d = 1'b1;
            state_d    = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        play_done_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (word_rd_en_c) begin
      hold_d      = bus.word_in;
      remaining_d = remaining_q - CNT_WIDTH'(1);
      phase_d     = PHASE_W'(1);
      state_d     = ST_EMIT;
    end

    // Abort wins over everything except the already-committed combinational pop.
    if (bus.play_abort) begin
      state_d        = ST_IDLE;
      hold_d         = '0;
      phase_d        = '0;
      remaining_d    = '0;
      words_done_d   = words_done_q;
      underrun_d     = underrun_q;
      sample_valid_d = 1'b0;
      play_done_d    = 1'b0;
    end

    play_busy_d = (state_d == ST_LOAD) || (state_d == ST_EMIT);
  end

  always_ff @(posedge adc_sampleclk or posedge ddr_usrreset) begin
    if (ddr_usrreset) begin
      state_q        <= ST_IDLE;
      hold_q         <= '0;
      phase_q        <= '0;
      remaining_q    <= '0;
      words_done_q   <= '0;
      sample_out_q   <= '0;
      sample_or_q    <= 1'b0;
      sample_trig_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      play_busy_q    <= 1'b0;
      play_done_q    <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      phase_q        <= phase_d;
      remaining_q    <= remaining_d;
      words_done_q   <= words_done_d;
      sample_out_q   <= sample_out_d;
      sample_or_q    <= sample_or_d;
      sample_trig_q  <= sample_trig_d;
      sample_valid_q <= sample_valid_d;
      play_busy_q    <= play_busy_d;
      play_done_q    <= play_done_d;
      underrun_q     <= underrun_d;
    end
  end

  assign bus.word_rd_en   = word_rd_en_c;
  assign bus.sample_out   = sample_out_q;
  assign bus.sample_or    = sample_or_q;
  assign bus.sample_trig  = sample_trig_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.play_busy    = play_busy_q;
  assign bus.play_done    = play_done_q;
  assign bus.underrun     = underrun_q;
  assign bus.words_done   = words_done_q;
endmodule

// File: tb/tb_adc_sample_unpacker.sv
// Bench for adc_sample_unpacker: FWFT FIFO model plus a sample scoreboard filled
// from the packed word format whenever a word is pushed into the FIFO.
module tb_adc_sample_unpacker;
  localparam int unsigned CNT_WIDTH = 32;

  logic adc_sampleclk = 1'b0;
  logic ddr_usrreset  = 1'b1;

  adc_sample_unpacker_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  adc_sample_unpacker #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .adc_sampleclk (adc_sampleclk),
    .ddr_usrreset  (ddr_usrreset),
    .bus           (bus)
  );

  always #5 adc_sampleclk = ~adc_sampleclk;

  int n_tests   = 0;
  int n_fail    = 0;
  int n_samples = 0;
  int n_rd      = 0;
  int n_done    = 0;
  int cyc       = 0;
  int first_v   = 0;
  int last_v    = 0;
  logic [31:0] fifo[$];
  logic [11:0] sb[$];
  logic [11:0] exp_s;

  task automatic fifo_refresh();
    bus.word_empty = (fifo.size() == 0);
    bus.word_in    = (fifo.size() == 0) ? 32'h0 : fifo[0];
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo.push_back(w);
    sb.push_back({w[31], w[30], w[9:0]});
    sb.push_back({w[31], w[30], w[19:10]});
    sb.push_back({w[31], w[30], w[29:20]});
    fifo_refresh();
  endtask

  task automatic flush();
    fifo.delete();
    sb.delete();
    fifo_refresh();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge adc_sampleclk);
      #1;
    end
  endtask

  task automatic clear_counts();
    n_samples = 0;
    n_rd      = 0;
    n_done    = 0;
  endtask

  task automatic start(input logic [31:0] n);
    bus.play_words = n;
    bus.play_start = 1'b1;
    tick(1);
    bus.play_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      tick(1);
      k++;
    end
    ok = (n_done != 0);
  endtask

  task automatic wait_samples(input int target, input int budget, output bit ok);
    int k = 0;
    while (n_samples < target && k < budget) begin
      tick(1);
      k++;
    end
    ok = (n_samples == target);
  endtask

  // FIFO pop on the edge the DUT takes the word; new head shows up just after the edge.
  always @(posedge adc_sampleclk) begin
    cyc = cyc + 1;
    if (bus.word_rd_en === 1'b1) begin
      n_rd++;
      n_tests++;
      if (fifo.size() == 0) begin
        n_fail++;
        $display("FAIL rd_on_empty: word_rd_en=1 with word_empty=1, required 0");
      end else begin
        void'(fifo.pop_front());
      end
      #1 fifo_refresh();
    end
  end

  always @(negedge adc_sampleclk) begin
    if (bus.play_done === 1'b1) n_done++;
    if (bus.sample_valid === 1'b1) begin
      if (n_samples == 0) first_v = cyc;
      last_v = cyc;
      n_samples++;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sample_unexpected: got or/trig/sample=%h, required no sample", {bus.sample_or, bus.sample_trig, bus.sample_out});
      end else begin
        exp_s = sb.pop_front();
        if ({bus.sample_or, bus.sample_trig, bus.sample_out} !== exp_s) begin
          n_fail++;
          $display("FAIL sample_value: got or/trig/sample=%h, required %h", {bus.sample_or, bus.sample_trig, bus.sample_out}, exp_s);
        end
      end
    end
  end

  task automatic test_reset();
    bus.play_start = 1'b0;
    bus.play_words = '0;
    bus.play_abort = 1'b0;
    ddr_usrreset   = 1'b1;
    flush();
    tick(3);
    ddr_usrreset = 1'b0;
    tick(1);
    n_tests++;
    if ({bus.word_rd_en, bus.sample_out, bus.sample_or, bus.sample_trig, bus.sample_valid,
         bus.play_busy, bus.play_done, bus.underrun} !== 17'h0 || bus.words_done !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: outputs not all 0 (valid=%b busy=%b words_done=%0d), required 0",
               bus.sample_valid, bus.play_busy, bus.words_done);
    end
  endtask

  task automatic test_single_word();
    logic [9:0] exp_tab [3];
    exp_tab[0] = 10'h2F1;
    exp_tab[1] = 10'h337;
    exp_tab[2] = 10'h0AB;
    push_word(32'h4ABC_DEF1);
    clear_counts();
    bus.play_words = 1;
    bus.play_start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      if (k == 1) begin
        bus.play_start = 1'b0;
        n_tests++;
        if (bus.word_rd_en !== 1'b1) begin
          n_fail++;
          $display("FAIL single_load_rd: word_rd_en=%b in cycle 1, required 1", bus.word_rd_en);
        end
      end
      n_tests++;
      if (bus.sample_valid !== 1'((k >= 3) && (k <= 5)) || bus.play_done !== 1'(k == 6)) begin
        n_fail++;
        $display("FAIL single_timing: cycle %0d valid=%b done=%b, required valid=%b done=%b",
                 k, bus.sample_valid, bus.play_done, (k >= 3) && (k <= 5), k == 6);
      end
      if (k >= 3 && k <= 5) begin
        n_tests++;
        if ({bus.sample_or, bus.sample_trig, bus.sample_out} !== {2'b01, exp_tab[k-3]}) begin
          n_fail++;
          $display("FAIL single_sample: cycle %0d got %h, required %h", k,
                   {bus.sample_or, bus.sample_trig, bus.sample_out}, {2'b01, exp_tab[k-3]});
        end
      end
    end
    n_tests++;
    if (bus.words_done !== 32'd1 || n_done != 1) begin
      n_fail++;
      $display("FAIL single_done: words_done=%0d done_pulses=%0d, required 1 and 1", bus.words_done, n_done);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 100; i++) push_word($urandom());
    clear_counts();
    start(100);
    wait_done(600, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_timeout: play_done=0 after 600 cycles, required 1");
    end
    tick(2);
    n_tests++;
    if (n_samples != 300 || (last_v - first_v + 1) != 300) begin
      n_fail++;
      $display("FAIL b2b_gapless: samples=%0d span=%0d, required 300 and 300", n_samples, last_v - first_v + 1);
    end
    n_tests++;
    if (n_rd != 100 || bus.words_done !== 32'd100 || bus.underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_counts: rd=%0d words_done=%0d underrun=%b, required 100 100 0", n_rd, bus.words_done, bus.underrun);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_leftover: %0d samples never emitted, required 0", sb.size());
    end
  endtask

  task automatic test_underrun();
    bit ok;
    push_word(32'h8123_4567);
    push_word(32'h3FFF_FC00);
    clear_counts();
    start(4);
    tick(9);
    n_tests++;
    if (n_samples != 6 || bus.underrun !== 1'b1 || bus.sample_valid !== 1'b0 || bus.play_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_stall: samples=%0d underrun=%b valid=%b busy=%b, required 6 1 0 1",
               n_samples, bus.underrun, bus.sample_valid, bus.play_busy);
    end
    push_word(32'hC00F_F3FF);
    tick(1);
    push_word(32'h0000_0001);
    n_tests++;
    if (bus.sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_resume_early: valid=%b one cycle after word, required 0", bus.sample_valid);
    end
    tick(1);
    n_tests++;
    if (bus.sample_valid !== 1'b1 || n_samples != 7) begin
      n_fail++;
      $display("FAIL underrun_resume: valid=%b samples=%0d two cycles after word, required 1 and 7", bus.sample_valid, n_samples);
    end
    wait_done(50, ok);
    n_tests++;
    if (!ok || n_samples != 12 || bus.words_done !== 32'd4 || bus.underrun !== 1'b1 || n_rd != 4) begin
      n_fail++;
      $display("FAIL underrun_finish: done=%b samples=%0d words_done=%0d underrun=%b rd=%0d, required 1 12 4 1 4",
               ok, n_samples, bus.words_done, bus.underrun, n_rd);
    end
    tick(2);
  endtask

  task automatic test_abort();
    bit ok;
    flush();
    for (int i = 0; i < 2; i++) push_word($urandom());
    clear_counts();
    start(10);
    tick(9);
    for (int i = 0; i < 8; i++) push_word($urandom());
    wait_samples(13, 200, ok);
    bus.play_abort = 1'b1;
    tick(1);
    bus.play_abort = 1'b0;
    n_tests++;
    if (!ok || bus.sample_valid !== 1'b0 || bus.play_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stop: reached=%b valid=%b busy=%b, required 1 0 0", ok, bus.sample_valid, bus.play_busy);
    end
    n_tests++;
    if (bus.words_done !== 32'd4 || bus.underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_hold: words_done=%0d underrun=%b, required 4 and 1", bus.words_done, bus.underrun);
    end
    tick(3);
    n_tests++;
    if (n_done != 0 || n_samples != 13 || n_rd != 5) begin
      n_fail++;
      $display("FAIL abort_quiet: done_pulses=%0d samples=%0d rd=%0d, required 0 13 5", n_done, n_samples, n_rd);
    end
    flush();
    push_word(32'h5555_AAAA);
    clear_counts();
    start(1);
    n_tests++;
    if (bus.underrun !== 1'b0 || bus.play_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_restart: underrun=%b busy=%b after start, required 0 and 1", bus.underrun, bus.play_busy);
    end
    wait_done(20, ok);
    n_tests++;
    if (!ok || bus.words_done !== 32'd1 || n_samples != 3) begin
      n_fail++;
      $display("FAIL abort_rerun: done=%b words_done=%0d samples=%0d, required 1 1 3", ok, bus.words_done, n_samples);
    end
    tick(2);
  endtask

  task automatic test_zero_and_busy_start();
    bit ok;
    push_word(32'h1234_5678);
    clear_counts();
    start(0);
    n_tests++;
    if (bus.play_done !== 1'b1 || bus.play_busy !== 1'b0 || n_rd != 0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b rd=%0d, required 1 0 0", bus.play_done, bus.play_busy, n_rd);
    end
    tick(1);
    n_tests++;
    if (bus.play_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_pulse_width: done=%b second cycle, required 0", bus.play_done);
    end
    tick(3);
    n_tests++;
    if (n_rd != 0 || n_done != 1) begin
      n_fail++;
      $display("FAIL zero_no_reads: rd=%0d done_pulses=%0d, required 0 and 1", n_rd, n_done);
    end
    push_word(32'hFFFF_FFFF);
    push_word(32'h0000_0000);
    clear_counts();
    start(3);
    tick(2);
    start(50);
    wait_done(40, ok);
    tick(2);
    n_tests++;
    if (!ok || bus.words_done !== 32'd3 || n_samples != 9 || n_rd != 3 || bus.play_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_ignored: done=%b words_done=%0d samples=%0d rd=%0d busy=%b, required 1 3 9 3 0",
               ok, bus.words_done, n_samples, n_rd, bus.play_busy);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    flush();
    for (int i = 0; i < 3; i++) push_word($urandom());
    clear_counts();
    start(3);
    wait_samples(2, 50, ok);
    #2 ddr_usrreset = 1'b1;
    #1;
    n_tests++;
    if (!ok || {bus.word_rd_en, bus.sample_out, bus.sample_or, bus.sample_trig, bus.sample_valid,
                bus.play_busy, bus.play_done, bus.underrun} !== 17'h0 || bus.words_done !== '0) begin
      n_fail++;
      $display("FAIL async_reset: reached=%b valid=%b busy=%b rd=%b words_done=%0d, required all 0",
               ok, bus.sample_valid, bus.play_busy, bus.word_rd_en, bus.words_done);
    end
    tick(2);
    ddr_usrreset = 1'b0;
    tick(5);
    n_tests++;
    if (n_rd != 1 || fifo.size() != 2 || bus.sample_valid !== 1'b0 || bus.play_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_no_read: rd=%0d fifo=%0d valid=%b busy=%b, required 1 2 0 0",
               n_rd, fifo.size(), bus.sample_valid, bus.play_busy);
    end
    flush();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_zero_and_busy_start();
    test_async_reset();
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
